// File: rtl/ws2812_pkg.sv
// ws2812_pkg
// Shared types and constants for the WS2812 serial output stage.
//   state_t     : FSM state encoding
//   FRAME_BITS  : bits per frame (GRB, 8 bits each)
//   *_DEF       : default bit/latch timing in clk cycles
package ws2812_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND_HIGH = 2'd1,
      SEND_LOW  = 2'd2,
      LATCH     = 2'd3
   } state_t;

   localparam int FRAME_BITS  = 24;
   localparam int BIT_CNT_W   = 5;

   localparam int T0H_DEF     = 4;
   localparam int T1H_DEF     = 8;
   localparam int BIT_DEF     = 13;
   localparam int RESET_DEF   = 600;

endpackage

// File: rtl/ws2812_if.sv
// ws2812_if
// Bundles the level/start request side and the status/serial side of the
// WS2812 driver.
//   level0/1/2 : red/green/blue levels (master -> slave)
//   start      : one-frame request      (master -> slave)
//   busy       : frame or latch gap in progress (slave -> master)
//   done       : one-cycle pulse at end of latch gap (slave -> master)
//   led_out    : serial line to the LED (slave -> master)
interface ws2812_if;

   logic [7:0] level0;
   logic [7:0] level1;
   logic [7:0] level2;
   logic       start;
   logic       busy;
   logic       done;
   logic       led_out;

   modport master (
      output level0, level1, level2, start,
      input  busy, done, led_out
   );

   modport slave (
      input  level0, level1, level2, start,
      output busy, done, led_out
   );

endinterface

// File: rtl/ws2812_driver.sv
// ws2812_driver
// Drives one WS2812-class LED over a one-wire NRZ link. A frame is 24 bits
// in GRB order, MSB first, followed by a low latch gap.
//   clk    : block clock
//   reset  : synchronous, active-high
//   bus    : ws2812_if.slave (levels, start, busy, done, led_out)
// Optional feature: define WS2812_AUTO_REFRESH_EN to launch a frame from IDLE
// whenever the levels differ from those captured for the previous frame.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | line low, waiting for start (or level change)
// SEND_HIGH | line high for T0H/T1H depending on current MSB
// SEND_LOW  | line low for the rest of the bit period
// LATCH     | line low for RESET_CYCLES, then done pulse
module ws2812_driver
   import ws2812_pkg::*;
#(
   parameter int T0H_CYCLES   = T0H_DEF,
   parameter int T1H_CYCLES   = T1H_DEF,
   parameter int BIT_CYCLES   = BIT_DEF,
   parameter int RESET_CYCLES = RESET_DEF
) (
   input  logic   clk,
   input  logic   reset,
   ws2812_if.slave bus
);

   localparam int CNT_MAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Terminal counts: the counter runs 0..N-1 in each state.
   localparam logic [CNT_W-1:0] T0H_LAST   = CNT_W'(T0H_CYCLES - 1);
   localparam logic [CNT_W-1:0] T1H_LAST   = CNT_W'(T1H_CYCLES - 1);
   localparam logic [CNT_W-1:0] T0L_LAST   = CNT_W'(BIT_CYCLES - T0H_CYCLES - 1);
   localparam logic [CNT_W-1:0] T1L_LAST   = CNT_W'(BIT_CYCLES - T1H_CYCLES - 1);
   localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

   state_t                 state, state_nxt;
   logic [FRAME_BITS-1:0]  shift_reg, shift_nxt;
   logic [BIT_CNT_W-1:0]   bit_cnt, bit_nxt;
   logic [CNT_W-1:0]       cyc_cnt, cyc_nxt;
   logic                   led_q, busy_q, done_q;
   logic                   launch;
   logic [FRAME_BITS-1:0]  levels;

   assign levels = {bus.level1, bus.level0, bus.level2};

`ifdef WS2812_AUTO_REFRESH_EN
   // Levels sent in the last frame; cleared by reset so that non-zero levels
   // after reset produce one frame.
   logic [FRAME_BITS-1:0] last_levels;

   assign launch = bus.start || (levels != last_levels);

   always_ff @(posedge clk) begin
      if (reset) begin
         last_levels <= '0;
      end else if (state == IDLE && launch) begin
         last_levels <= levels;
      end
   end
`else
   assign launch = bus.start;
`endif

   always_comb begin
      state_nxt = state;
      shift_nxt = shift_reg;
      bit_nxt   = bit_cnt;
      cyc_nxt   = cyc_cnt + CNT_W'(1);
      case (state)
         IDLE: begin
            cyc_nxt = '0;
            if (launch) begin
               state_nxt = SEND_HIGH;
               shift_nxt = levels;
               bit_nxt   = '0;
            end
         end
         SEND_HIGH: begin
            if (cyc_cnt == (shift_reg[FRAME_BITS-1] ? T1H_LAST : T0H_LAST)) begin
               state_nxt = SEND_LOW;
               cyc_nxt   = '0;
            end
         end
         SEND_LOW: begin
            // MSB is still the bit being sent; shifting happens at the end.
            if (cyc_cnt == (shift_reg[FRAME_BITS-1] ? T1L_LAST : T0L_LAST)) begin
               cyc_nxt   = '0;
               shift_nxt = {shift_reg[FRAME_BITS-2:0], 1'b0};
               if (bit_cnt == LAST_BIT) begin
                  state_nxt = LATCH;
                  bit_nxt   = '0;
               end else begin
                  state_nxt = SEND_HIGH;
                  bit_nxt   = bit_cnt + BIT_CNT_W'(1);
               end
            end
         end
         LATCH: begin
            if (cyc_cnt == LATCH_LAST) begin
               state_nxt = IDLE;
               cyc_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            cyc_nxt   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         cyc_cnt   <= '0;
         led_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         shift_reg <= shift_nxt;
         bit_cnt   <= bit_nxt;
         cyc_cnt   <= cyc_nxt;
         led_q     <= (state_nxt == SEND_HIGH);
         busy_q    <= (state_nxt != IDLE);
         done_q    <= (state == LATCH) && (state_nxt == IDLE);
      end
   end

   assign bus.led_out = led_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// tb_ws2812_driver
// Directed bench for ws2812_driver: decodes the serial line bit by bit and
// compares frame content, bit timing and done timing against hand-computed
// values. Define WS2812_AUTO_REFRESH_EN to exercise the auto-refresh build.
module tb_ws2812_driver;

   localparam int T1H       = 8;
   localparam int T0H       = 4;
   localparam int BIT_P     = 13;
   localparam int FRAME_LEN = 912;

   logic clk = 1'b0;
   logic reset;

   ws2812_if bus ();

   ws2812_driver dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc      = 0;
   int n_vec    = 0;
   int n_err    = 0;
   int done_cnt = 0;
   int both_cnt = 0;
   int d0;

   always @(posedge clk) begin
      cyc++;
      #1;
      if (bus.done) done_cnt++;
      if (bus.busy && bus.done) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
   endtask

   // Receive one frame starting at (or waiting for) the first rise; returns
   // at the negedge sample where done is high.
   task automatic rx_frame(input string tag, input logic [23:0] exp_data);
      int t, h, l, bad_per, bad_hi, hi_latch, rise_cyc;
      logic [23:0] data;
      t = 0;
      while (!bus.led_out && t < 2000) begin
         t++;
         @(negedge clk);
      end
      chk({tag, "_rise"}, 32'(bus.led_out), 32'd1);
      if (!bus.led_out) return;
      rise_cyc = cyc;
      data     = '0;
      bad_per  = 0;
      bad_hi   = 0;
      for (int i = 0; i < 24; i++) begin
         h = 0;
         while (bus.led_out && h < 20) begin
            h++;
            @(negedge clk);
         end
         data = {data[22:0], (h == T1H)};
         if (h != T1H && h != T0H) bad_hi++;
         if (i < 23) begin
            l = 0;
            while (!bus.led_out && l < 20) begin
               l++;
               @(negedge clk);
            end
            if (h + l != BIT_P) bad_per++;
         end
      end
      t        = 0;
      hi_latch = 0;
      while (!bus.done && t < 2000) begin
         if (bus.led_out) hi_latch++;
         t++;
         @(negedge clk);
      end
      chk({tag, "_data"},      32'(data),            32'(exp_data));
      chk({tag, "_high_w"},    32'(bad_hi),          32'd0);
      chk({tag, "_period"},    32'(bad_per),         32'd0);
      chk({tag, "_latch_low"}, 32'(hi_latch),        32'd0);
      chk({tag, "_done_at"},   32'(cyc - rise_cyc),  32'(FRAME_LEN));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.level0 = 8'h00;
      bus.level1 = 8'h00;
      bus.level2 = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_led",  32'(bus.led_out), 32'd0);
      chk("rst_busy", 32'(bus.busy),    32'd0);
      chk("rst_done", 32'(bus.done),    32'd0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

`ifdef WS2812_AUTO_REFRESH_EN
      chk("auto_idle0", 32'(bus.busy), 32'd0);
      bus.level0 = 8'h10;
      @(negedge clk);
      chk("auto1_start", 32'(bus.led_out), 32'd1);
      rx_frame("auto1", 24'h001000);
      repeat (20) @(negedge clk);
      chk("auto_steady1", 32'(bus.busy), 32'd0);
      bus.level0 = 8'h11;
      @(negedge clk);
      chk("auto2_start", 32'(bus.led_out), 32'd1);
      rx_frame("auto2", 24'h001100);
      d0 = done_cnt;
      repeat (700) @(negedge clk);
      chk("auto_no_more", 32'(done_cnt - d0), 32'd0);
      chk("auto_idle_end", 32'(bus.busy), 32'd0);
`else
      // Frame content and first-rise latency.
      bus.level0 = 8'hFF;
      bus.level1 = 8'h00;
      bus.level2 = 8'hA5;
      d0 = done_cnt;
      pulse_start();
      chk("first_rise", 32'(bus.led_out), 32'd1);
      chk("first_busy", 32'(bus.busy),    32'd1);
      rx_frame("frame", 24'h00FFA5);
      chk("frame_done_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk("frame_done_cnt", 32'(done_cnt - d0), 32'd1);

      // start re-asserted mid-frame and during the latch gap.
      repeat (5) @(negedge clk);
      d0 = done_cnt;
      pulse_start();
      fork
         rx_frame("busy_start", 24'h00FFA5);
         begin
            repeat (99) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk) bus.start = 1'b0;
            repeat (399) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk) bus.start = 1'b0;
         end
      join
      repeat (30) @(negedge clk);
      chk("busy_start_idle",  32'(bus.led_out | bus.busy), 32'd0);
      chk("busy_start_dones", 32'(done_cnt - d0),          32'd1);

      // Level change during bit 5 does not affect the frame.
      pulse_start();
      fork
         rx_frame("mid_change", 24'h00FFA5);
         begin
            repeat (65) @(negedge clk);
            bus.level2 = 8'h00;
         end
      join
      repeat (5) @(negedge clk);

      // Reset at the start of bit 10 (an R '1' bit, so the line is high).
      pulse_start();
      repeat (130) @(negedge clk);
      chk("pre_reset_high", 32'(bus.led_out), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_led",  32'(bus.led_out), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy),    32'd0);
      chk("mid_rst_done", 32'(bus.done),    32'd0);
      reset = 1'b0;
      d0 = done_cnt;
      repeat (700) @(negedge clk);
      chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
      bus.level0 = 8'h3C;
      bus.level1 = 8'h81;
      bus.level2 = 8'h00;
      pulse_start();
      rx_frame("after_rst", 24'h813C00);
      repeat (5) @(negedge clk);

      // Back-to-back frames with start held high.
      bus.level0 = 8'h5A;
      bus.level1 = 8'hC3;
      bus.level2 = 8'h0F;
      @(negedge clk) bus.start = 1'b1;
      rx_frame("b2b1", 24'hC35A0F);
      chk("b2b_done_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk("b2b_gap", 32'(bus.led_out), 32'd1);
      bus.start = 1'b0;
      rx_frame("b2b2", 24'hC35A0F);
      repeat (20) @(negedge clk);
      chk("b2b_idle", 32'(bus.busy), 32'd0);

      // Without auto-refresh, level changes while idle launch nothing.
      bus.level0 = 8'h11;
      repeat (30) @(negedge clk);
      chk("no_auto_led",  32'(bus.led_out), 32'd0);
      chk("no_auto_busy", 32'(bus.busy),    32'd0);
`endif

      chk("busy_done_overlap", 32'(both_cnt), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
